// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: MEM-stage ramOp codes and
// arbiter FSM state encodings. Optional watchdog: MEM_ARB_TIMEOUT_EN.
package mem_bus_arbiter_pkg;

    // ramOp codes issued by the MEM stage
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_D_ACC  = 3'd1,
        ARB_I_ACC  = 3'd2,
        ARB_D_DONE = 3'd3,
        ARB_I_DONE = 3'd4
    } arb_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External RAM port: request bundle out, ack/read data back.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter_byte_lane.sv
// Byte-lane steering: store side produces be/we/replicated wdata from the
// live request; load side extends the returned word per the captured op.
module mem_byte_lane
    import mem_bus_arbiter_pkg::*;
(
    input  logic [3:0]  i_st_op,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic        o_we,
    output logic [31:0] o_wdata,
    input  logic [3:0]  i_ld_op,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store path: byte enables and lane replication; loads read the full word
    always_comb begin
        o_be    = BE_WORD;
        o_we    = 1'b0;
        o_wdata = '0;
        case (i_st_op)
            MEM_SB: begin
                o_we    = 1'b1;
                o_be    = 4'b0001 << i_st_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_SH: begin
                o_we    = 1'b1;
                o_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            MEM_SW: begin
                o_we    = 1'b1;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    // Load path: select byte/half by address, then sign/zero extend
    always_comb begin
        w_byte  = i_rdata[7:0];
        case (i_ld_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half  = i_ld_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_rdata = '0;
        case (i_ld_op)
            MEM_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_rdata = {24'd0, w_byte};
            MEM_LH:  o_rdata = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_rdata = {16'd0, w_half};
            MEM_LW:  o_rdata = i_rdata;
            default: o_rdata = '0;
        endcase
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single RAM port between IF fetches and MEM loads/stores.
// Data wins ties (older instruction); no preemption; success levels are held
// until pipe_advance_i. Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_success_o,
    output logic [31:0]       inst_rdata_o,
    input  logic [3:0]        data_ramop_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_success_o,
    output logic [31:0]       data_rdata_o,
    input  logic              pipe_advance_i,
    mem_bus_arbiter_if.master ram
`ifdef MEM_ARB_TIMEOUT_EN
    , output logic            bus_error_o
`endif
);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    arb_state_e  r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_lo;

    logic [3:0]  w_be;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_rdata;
    logic        w_timeout;

    mem_byte_lane u_lane (
        .i_st_op (data_ramop_i),
        .i_st_lo (data_addr_i[1:0]),
        .i_wdata (data_wdata_i),
        .o_be    (w_be),
        .o_we    (w_we),
        .o_wdata (w_wdata),
        .i_ld_op (r_op),
        .i_ld_lo (r_lo),
        .i_rdata (ram.rdata),
        .o_rdata (w_ld_rdata)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_cnt;

    // Watchdog: counts access cycles without ack, cleared on every grant
    always_ff @(posedge clk) begin
        if (rst || r_state == ARB_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == ARB_D_ACC || r_state == ARB_I_ACC) && !ram.ack && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !ram.ack;
`else
    assign w_timeout = 1'b0;
`endif

    // Arbiter FSM with all RAM/requester outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_IDLE;
            r_op           <= '0;
            r_lo           <= '0;
            ram.req        <= 1'b0;
            ram.we         <= 1'b0;
            ram.be         <= '0;
            ram.addr       <= '0;
            ram.wdata      <= '0;
            inst_success_o <= 1'b0;
            inst_rdata_o   <= '0;
            data_success_o <= 1'b0;
            data_rdata_o   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus_error_o    <= 1'b0;
`endif
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            bus_error_o <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (data_ramop_i != MEM_NOP) begin
                        r_state   <= ARB_D_ACC;
                        r_op      <= data_ramop_i;
                        r_lo      <= data_addr_i[1:0];
                        ram.req   <= 1'b1;
                        ram.we    <= w_we;
                        ram.be    <= w_be;
                        ram.addr  <= data_addr_i & ADDR_MASK;
                        ram.wdata <= w_wdata;
                    end else if (inst_req_i) begin
                        r_state   <= ARB_I_ACC;
                        ram.req   <= 1'b1;
                        ram.we    <= 1'b0;
                        ram.be    <= BE_WORD;
                        ram.addr  <= inst_addr_i & ADDR_MASK;
                        ram.wdata <= '0;
                    end
                end
                ARB_D_ACC: begin
                    if (ram.ack || w_timeout) begin
                        r_state        <= ARB_D_DONE;
                        ram.req        <= 1'b0;
                        data_success_o <= 1'b1;
                        data_rdata_o   <= ram.ack ? w_ld_rdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        bus_error_o    <= w_timeout;
`endif
                    end
                end
                ARB_I_ACC: begin
                    if (ram.ack || w_timeout) begin
                        r_state        <= ARB_I_DONE;
                        ram.req        <= 1'b0;
                        inst_success_o <= 1'b1;
                        inst_rdata_o   <= ram.ack ? ram.rdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        bus_error_o    <= w_timeout;
`endif
                    end
                end
                ARB_D_DONE: begin
                    if (pipe_advance_i) begin
                        r_state        <= ARB_IDLE;
                        data_success_o <= 1'b0;
                    end
                end
                ARB_I_DONE: begin
                    if (pipe_advance_i) begin
                        r_state        <= ARB_IDLE;
                        inst_success_o <= 1'b0;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: byte-lane table plus handshake sequences.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_success_o;
    logic [31:0] inst_rdata_o;
    logic [3:0]  data_ramop_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_success_o;
    logic [31:0] data_rdata_o;
    logic        pipe_advance_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        bus_error_o;
`endif

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(32)) ram_if ();

    mem_bus_arbiter #(
        .ADDR_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_i     (inst_req_i),
        .inst_addr_i    (inst_addr_i),
        .inst_success_o (inst_success_o),
        .inst_rdata_o   (inst_rdata_o),
        .data_ramop_i   (data_ramop_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_success_o (data_success_o),
        .data_rdata_o   (data_rdata_o),
        .pipe_advance_i (pipe_advance_i),
        .ram            (ram_if.master)
`ifdef MEM_ARB_TIMEOUT_EN
        , .bus_error_o  (bus_error_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ram_rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic        chk_wd;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One complete data access with a 1-cycle-ack RAM
    task automatic run_vec(input vec_t v);
        data_ramop_i = v.op;
        data_addr_i  = v.addr;
        data_wdata_i = v.wdata;
        tick();
        data_ramop_i = MEM_NOP;
        data_wdata_i = 32'h0;
        chk({v.name, " req"},  32'(ram_if.req), 32'd1);
        chk({v.name, " addr"}, ram_if.addr, v.exp_addr);
        chk({v.name, " be"},   32'(ram_if.be), 32'(v.exp_be));
        chk({v.name, " we"},   32'(ram_if.we), 32'(v.exp_we));
        if (v.chk_wd) chk({v.name, " wdata"}, ram_if.wdata, v.exp_wdata);
        ram_if.ack   = 1'b1;
        ram_if.rdata = v.ram_rdata;
        tick();
        ram_if.ack   = 1'b0;
        chk({v.name, " success"}, 32'(data_success_o), 32'd1);
        chk({v.name, " rdata"},   data_rdata_o, v.exp_rdata);
        chk({v.name, " req drop"}, 32'(ram_if.req), 32'd0);
        pipe_advance_i = 1'b1;
        tick();
        pipe_advance_i = 1'b0;
        chk({v.name, " release"}, 32'(data_success_o), 32'd0);
    endtask

    initial begin
        //          name        op       addr           wdata          ram_rdata      exp_addr       be       we    chkwd  exp_wdata      exp_rdata
        vt[0]  = '{"SB+3",   MEM_SB,  32'h1000_0003, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h1000_0000, 4'b1000, 1'b1, 1'b1, 32'hABAB_ABAB, 32'h0};
        vt[1]  = '{"SB+1",   MEM_SB,  32'h1000_0001, 32'h5555_55CD, 32'hDEAD_BEEF, 32'h1000_0000, 4'b0010, 1'b1, 1'b1, 32'hCDCD_CDCD, 32'h0};
        vt[2]  = '{"SH+2",   MEM_SH,  32'h1000_0002, 32'h0000_1234, 32'hDEAD_BEEF, 32'h1000_0000, 4'b1100, 1'b1, 1'b1, 32'h1234_1234, 32'h0};
        vt[3]  = '{"SH+0",   MEM_SH,  32'h1000_0008, 32'hFFFF_5678, 32'hDEAD_BEEF, 32'h1000_0008, 4'b0011, 1'b1, 1'b1, 32'h5678_5678, 32'h0};
        vt[4]  = '{"SW",     MEM_SW,  32'h1000_0004, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1000_0004, 4'hF,    1'b1, 1'b1, 32'hCAFE_F00D, 32'h0};
        vt[5]  = '{"LB+3",   MEM_LB,  32'h2000_0003, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'hFFFF_FF80};
        vt[6]  = '{"LBU+3",  MEM_LBU, 32'h2000_0003, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_0080};
        vt[7]  = '{"LH+2",   MEM_LH,  32'h2000_0002, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'hFFFF_80FF};
        vt[8]  = '{"LHU+0",  MEM_LHU, 32'h2000_0000, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_7F01};
        vt[9]  = '{"LW",     MEM_LW,  32'h2000_0010, 32'h0,         32'h80FF_7F01, 32'h2000_0010, 4'hF,    1'b0, 1'b0, 32'h0,         32'h80FF_7F01};
        vt[10] = '{"LB+1",   MEM_LB,  32'h2000_0001, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_007F};
        vt[11] = '{"LBU+2",  MEM_LBU, 32'h2000_0002, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_00FF};
        vt[12] = '{"LH+0",   MEM_LH,  32'h2000_0000, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_7F01};
        vt[13] = '{"LHU+2",  MEM_LHU, 32'h2000_0002, 32'h0,         32'h80FF_7F01, 32'h2000_0000, 4'hF,    1'b0, 1'b0, 32'h0,         32'h0000_80FF};

        ram_if.ack   = 1'b0;
        ram_if.rdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst req",      32'(ram_if.req), 32'd0);
        chk("rst be",       32'(ram_if.be), 32'd0);
        chk("rst addr",     ram_if.addr, 32'd0);
        chk("rst isucc",    32'(inst_success_o), 32'd0);
        chk("rst dsucc",    32'(data_success_o), 32'd0);
        chk("rst drdata",   data_rdata_o, 32'd0);
        rst = 1'b0;
        tick();

        // IF-only fetch, RAM stalls one cycle before acking
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h8000_0004;
        tick();
        inst_req_i  = 1'b0;
        chk("if req",  32'(ram_if.req), 32'd1);
        chk("if addr", ram_if.addr, 32'h8000_0004);
        chk("if be",   32'(ram_if.be), 32'hF);
        chk("if we",   32'(ram_if.we), 32'd0);
        tick();
        chk("if stall req",  32'(ram_if.req), 32'd1);
        chk("if stall addr", ram_if.addr, 32'h8000_0004);
        chk("if stall succ", 32'(inst_success_o), 32'd0);
        ram_if.ack   = 1'b1;
        ram_if.rdata = 32'h2408_0001;
        tick();
        ram_if.ack   = 1'b0;
        chk("if succ",  32'(inst_success_o), 32'd1);
        chk("if rdata", inst_rdata_o, 32'h2408_0001);
        chk("if req drop", 32'(ram_if.req), 32'd0);
        tick();
        chk("if hold", 32'(inst_success_o), 32'd1);
        pipe_advance_i = 1'b1;
        tick();
        pipe_advance_i = 1'b0;
        chk("if release", 32'(inst_success_o), 32'd0);

        // Byte-lane table
        for (int i = 0; i < 14; i++) run_vec(vt[i]);

        // Simultaneous IF and LW: data first, IF only after release
        inst_req_i   = 1'b1;
        inst_addr_i  = 32'h8000_0008;
        data_ramop_i = MEM_LW;
        data_addr_i  = 32'h8040_0000;
        tick();
        data_ramop_i = MEM_NOP;
        chk("pri addr", ram_if.addr, 32'h8040_0000);
        chk("pri we",   32'(ram_if.we), 32'd0);
        ram_if.ack   = 1'b1;
        ram_if.rdata = 32'h1122_3344;
        tick();
        ram_if.ack   = 1'b0;
        chk("pri dsucc", 32'(data_success_o), 32'd1);
        chk("pri drdata", data_rdata_o, 32'h1122_3344);
        chk("pri isucc", 32'(inst_success_o), 32'd0);
        tick();
        chk("pri wait req", 32'(ram_if.req), 32'd0);
        pipe_advance_i = 1'b1;
        tick();
        pipe_advance_i = 1'b0;
        chk("pri release", 32'(data_success_o), 32'd0);
        chk("pri no same-cycle grant", 32'(ram_if.req), 32'd0);
        tick();
        inst_req_i = 1'b0;
        chk("pri if req",  32'(ram_if.req), 32'd1);
        chk("pri if addr", ram_if.addr, 32'h8000_0008);
        ram_if.ack   = 1'b1;
        ram_if.rdata = 32'h0000_0013;
        tick();
        ram_if.ack   = 1'b0;
        chk("pri if succ",  32'(inst_success_o), 32'd1);
        chk("pri if rdata", inst_rdata_o, 32'h0000_0013);
        pipe_advance_i = 1'b1;
        tick();
        pipe_advance_i = 1'b0;

        // Reset during D_ACC coincident with ack; a later ack is ignored
        data_ramop_i = MEM_SW;
        data_addr_i  = 32'h3000_0000;
        data_wdata_i = 32'h7777_7777;
        tick();
        data_ramop_i = MEM_NOP;
        chk("rstacc req", 32'(ram_if.req), 32'd1);
        rst          = 1'b1;
        ram_if.ack   = 1'b1;
        ram_if.rdata = 32'h9999_9999;
        tick();
        rst = 1'b0;
        chk("rstacc req0",  32'(ram_if.req), 32'd0);
        chk("rstacc dsucc", 32'(data_success_o), 32'd0);
        chk("rstacc we",    32'(ram_if.we), 32'd0);
        tick();
        ram_if.ack = 1'b0;
        chk("late ack req",  32'(ram_if.req), 32'd0);
        chk("late ack succ", 32'(data_success_o), 32'd0);
        tick();
        chk("late ack idle", 32'(data_success_o), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: leave a nonzero rdata first so the forced zero is visible
        run_vec(vt[9]);
        data_ramop_i = MEM_LW;
        data_addr_i  = 32'h4000_0000;
        tick();
        data_ramop_i = MEM_NOP;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wd pre err", 32'(bus_error_o), 32'd0);
            chk("wd pre req", 32'(ram_if.req), 32'd1);
        end
        tick();
        chk("wd err",   32'(bus_error_o), 32'd1);
        chk("wd req",   32'(ram_if.req), 32'd0);
        chk("wd succ",  32'(data_success_o), 32'd1);
        chk("wd rdata", data_rdata_o, 32'd0);
        tick();
        chk("wd pulse", 32'(bus_error_o), 32'd0);
        pipe_advance_i = 1'b1;
        tick();
        pipe_advance_i = 1'b0;
        chk("wd release", 32'(data_success_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external RAM port between instruction fetch (IF) and the MEM stage's load/store path.
- Sequences each access with a request/ack handshake.
- Generates byte enables and store-data replication; sign/zero-extends load data.
- Returns per-requester success levels that drive the pipeline's pause logic.

Parameters:
- ADDR_W, 32, byte address width of both requesters and the RAM port.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- inst_req_i  in  1  IF requests a word fetch.
- inst_addr_i  in  ADDR_W  fetch byte address.
- inst_success_o  out  1  fetch complete; held until pipe_advance_i.
- inst_rdata_o  out  32  fetched word.
- data_ramop_i  in  4  MEM ramOp code (MEM_NOP/LB/LBU/LH/LHU/LW/SB/SH/SW).
- data_addr_i  in  ADDR_W  load/store byte address.
- data_wdata_i  in  32  store data, right-justified.
- data_success_o  out  1  data access complete; held until pipe_advance_i.
- data_rdata_o  out  32  extended load result.
- pipe_advance_i  in  1  pipeline registers latch this cycle; releases DONE states.
- ram_req_o  out  1  RAM request.
- ram_we_o  out  1  write strobe.
- ram_be_o  out  4  byte enables.
- ram_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- ram_wdata_o  out  32  replicated store data.
- ram_ack_i  in  1  RAM completes the current request this cycle.
- ram_rdata_i  in  32  read word, valid with ram_ack_i.
- bus_error_o  out  1  watchdog abort pulse; present only with the optional feature.

Behaviour:
- All outputs registered. Reset value 0 for every output; FSM state IDLE.
- FSM states:
  - IDLE: no access in flight.
  - D_ACC / I_ACC: data / instruction access in flight.
  - D_DONE / I_DONE: access complete; success held for the requester.
- IDLE, cycle N, requests sampled:
  - data_ramop_i != MEM_NOP -> D_ACC. Data has fixed priority; it is the older instruction.
  - Else inst_req_i -> I_ACC.
  - ram_req_o and the address/we/be/wdata bundle are valid from cycle N+1.
- D_ACC/I_ACC: ram_req_o and bundle held stable until ram_ack_i.
  - On the ack cycle, ram_rdata_i is captured and ram_req_o drops at the next edge.
  - Next state is D_DONE/I_DONE; the success output is 1 from the cycle after ack.
- D_DONE/I_DONE: success level and rdata held.
  - pipe_advance_i=1 -> IDLE, success cleared at the same edge.
  - Next arbitration occurs in IDLE, not in the same cycle.
  - Minimum latency with a 1-cycle-ack RAM is 3 cycles from request to success.
- No preemption. An IF request arriving during D_ACC waits.
- Requests are not latched. If the requester withdraws before grant, nothing is issued. Once granted, the address/op captured at grant is used.
- Byte enables:
  - SB: 4'b0001 << addr[1:0], wdata {4{b}}.
  - SH: addr[1] ? 4'b1100 : 4'b0011, wdata {2{h}}.
  - SW: 4'hF.
  - Loads and fetches: be 4'hF, we 0.
- Load extension:
  - LB/LBU select byte addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU select half addr[1]; LH sign-extends, LHU zero-extends.
  - LW: word unchanged.
  - Stores return data_rdata_o = 0.
- Misaligned addresses are not checked here. MEM already nulls faulting ops to MEM_NOP.
- rst during any state: next edge returns to IDLE, all outputs 0. An abandoned RAM request is not retried.
- A simultaneous ack and rst loses the ack.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in D_ACC/I_ACC and clears on entry.
  - Reaching TIMEOUT_CYCLES without ack drops ram_req_o, pulses bus_error_o for 1 cycle, and enters the DONE state with rdata 0. The pipeline is never wedged.
- Undefined: no counter and no bus_error_o port; waits indefinitely for ram_ack_i.

Decomposition:
- Shared defines header: MEM_* ramOp codes (existing) and FSM state encodings (new ARB_* constants).
- One sub-module: mem_byte_lane. Purely combinational: ramOp + addr[1:0] + wdata/rdata -> be, replicated wdata, extended rdata. Instantiated twice conceptually (store path, load path) or once with both outputs.

Test Plan:
- IF-only fetch of 0x8000_0004, RAM acks in 1 cycle with 0x2408_0001 -> ram_addr 0x8000_0004, be 0xF, we 0; inst_success_o=1 with rdata 0x2408_0001 at cycle 3; cleared after pipe_advance_i.
- Simultaneous IF fetch and LW at 0x8040_0000 -> data granted first; IF issued only after D_DONE released by pipe_advance_i.
- SB 0xAB at 0x...03 -> be 4'b1000, wdata 0xABABABAB, we 1. SH 0x1234 at 0x...02 -> be 4'b1100, wdata 0x12341234.
- RAM word 0x80FF_7F01: LB @+3 -> 0xFFFFFF80; LBU @+3 -> 0x00000080; LH @+2 -> 0xFFFF80FF; LHU @+0 -> 0x00007F01.
- rst asserted during D_ACC with ack pending -> next cycle ram_req_o=0, success 0, state IDLE; later ack ignored.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack -> bus_error_o one-cycle pulse, data_success_o=1 with rdata 0, ram_req_o dropped.
